// File: rtl/axi_tlb_l1_programmer.sv
// axi_tlb_l1_programmer: turns TLB program/invalidate commands into an
// ordered series of AXI4-Lite register writes on the table's config port.
package axi_tlb_l1_programmer_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } cfg_ax_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } cfg_w_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } cfg_r_t;
    typedef struct packed {
        cfg_ax_t aw;
        logic    aw_valid;
        cfg_w_t  w;
        logic    w_valid;
        logic    b_ready;
        cfg_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } cfg_req_t;
    typedef struct packed {
        logic       aw_ready;
        logic       w_ready;
        logic [1:0] b_resp;
        logic       b_valid;
        logic       ar_ready;
        cfg_r_t     r;
        logic       r_valid;
    } cfg_resp_t;
endpackage

module axi_tlb_l1_programmer
    import axi_tlb_l1_programmer_pkg::*;
#(
    parameter int unsigned NumEntries      = 4,
    parameter int unsigned InpAddrWidth    = 32,
    parameter int unsigned OupAddrWidth    = 32,
    parameter int unsigned CfgAxiAddrWidth = 32,
    parameter int unsigned CfgAxiDataWidth = 32,
    parameter logic [CfgAxiAddrWidth-1:0] CfgBaseAddr = '0,
    parameter type axi_lite_req_t  = cfg_req_t,
    parameter type axi_lite_resp_t = cfg_resp_t,
    localparam int unsigned IdxW     = (NumEntries > 1) ? $clog2(NumEntries) : 1,
    localparam int unsigned InpPageW = InpAddrWidth - 12,
    localparam int unsigned OupPageW = OupAddrWidth - 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_op_i,
    input  logic [IdxW-1:0]     cmd_idx_i,
    input  logic [InpPageW-1:0] cmd_first_i,
    input  logic [InpPageW-1:0] cmd_last_i,
    input  logic [OupPageW-1:0] cmd_base_i,
    input  logic [2:0]          cmd_flags_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [1:0]          rsp_err_o,
    output logic                busy_o,
    output axi_lite_req_t       cfg_req_o,
    input  axi_lite_resp_t      cfg_resp_i
);

    if (CfgAxiDataWidth != 32) begin : g_bad_data_width
        $error("CfgAxiDataWidth must be 32");
    end

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [1:0]          err_q, err_d;
    logic                op_q, op_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [InpPageW-1:0] first_q, first_d;
    logic [InpPageW-1:0] last_q, last_d;
    logic [OupPageW-1:0] base_q, base_d;
    logic [2:0]          flags_q, flags_d;

    logic                       cmd_bad;
    logic                       aw_hs;
    logic                       w_hs;
    logic                       last_step;
    logic [3:0]                 reg_off;
    logic [31:0]                wr_data;
    logic [CfgAxiAddrWidth-1:0] wr_addr;
    logic                       unused_rd;

    assign cmd_ready_o = (state_q == StIdle) && !rst_i;
    assign busy_o      = state_q != StIdle;
    assign rsp_valid_o = state_q == StDone;
    assign rsp_err_o   = rsp_valid_o ? err_q : 2'd0;

    assign cmd_bad = (32'(cmd_idx_i) >= NumEntries)
                  || (!cmd_op_i && (cmd_first_i > cmd_last_i));
    assign aw_hs     = cfg_req_o.aw_valid && cfg_resp_i.aw_ready;
    assign w_hs      = cfg_req_o.w_valid && cfg_resp_i.w_ready;
    assign last_step = step_q == (op_q ? 3'd0 : 3'd4);
    assign unused_rd = ^{cfg_resp_i.ar_ready, cfg_resp_i.r, cfg_resp_i.r_valid};

    // Flags are cleared first and rewritten last so a half-updated
    // range is never visible as a valid entry.
    always_comb begin
        reg_off = 4'hC;
        wr_data = 32'd0;
        case (step_q)
            3'd0: begin reg_off = 4'hC; wr_data = 32'd0; end
            3'd1: begin reg_off = 4'h0; wr_data = 32'(first_q); end
            3'd2: begin reg_off = 4'h4; wr_data = 32'(last_q); end
            3'd3: begin reg_off = 4'h8; wr_data = 32'(base_q); end
            default: begin reg_off = 4'hC; wr_data = 32'(flags_q); end
        endcase
        wr_addr = CfgBaseAddr
                + (CfgAxiAddrWidth'(idx_q) << 4)
                + CfgAxiAddrWidth'(reg_off);
    end

    always_comb begin
        cfg_req_o          = '0;
        cfg_req_o.aw.addr  = wr_addr;
        cfg_req_o.aw.prot  = 3'b000;
        cfg_req_o.aw_valid = (state_q == StAddr) && !aw_done_q;
        cfg_req_o.w.data   = wr_data;
        cfg_req_o.w.strb   = 4'hF;
        cfg_req_o.w_valid  = (state_q == StAddr) && !w_done_q;
        cfg_req_o.b_ready  = state_q == StResp;
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        op_d      = op_q;
        idx_d     = idx_q;
        first_d   = first_q;
        last_d    = last_q;
        base_d    = base_q;
        flags_d   = flags_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    op_d      = cmd_op_i;
                    idx_d     = cmd_idx_i;
                    first_d   = cmd_first_i;
                    last_d    = cmd_last_i;
                    base_d    = cmd_base_i;
                    flags_d   = cmd_flags_i;
                    step_d    = 3'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = cmd_bad ? 2'd1 : 2'd0;
                    state_d   = cmd_bad ? StDone : StAddr;
                end
            end
            StAddr: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (cfg_resp_i.b_valid) begin
                    if (cfg_resp_i.b_resp != 2'b00) begin
                        err_d   = 2'd2;
                        state_d = StDone;
                    end else if (last_step) begin
                        err_d   = 2'd0;
                        state_d = StDone;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = StAddr;
                    end
                end
            end
            default: begin
                if (rsp_ready_i) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            step_q    <= 3'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 2'd0;
            op_q      <= 1'b0;
            idx_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            base_q    <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            last_q    <= last_d;
            base_q    <= base_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: tb/tb_axi_tlb_l1_programmer.sv
// Bench for axi_tlb_l1_programmer: transaction-level model of the entry
// layout and response timing, a scripted config slave, per-cycle checks.
module tb_axi_tlb_l1_programmer;
    import axi_tlb_l1_programmer_pkg::*;

    localparam int NE = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_op_i = 1'b0;
    logic [1:0]  cmd_idx_i = '0;
    logic [19:0] cmd_first_i = '0;
    logic [19:0] cmd_last_i = '0;
    logic [19:0] cmd_base_i = '0;
    logic [2:0]  cmd_flags_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [1:0]  rsp_err_o;
    logic        busy_o;
    cfg_req_t    cfg_req_o;
    cfg_resp_t   cfg_resp_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    bit         in_flight = 0;
    bit         zw = 0;
    int         t_acc = 0;
    int         exp_lat = 0;
    logic [1:0] exp_err = 2'd0;
    wr_t        exp_q[$];
    wr_t        log_q[$];
    int         acc_cnt = 0;
    int         rsp_cnt = 0;
    int         done_cnt = 0;
    int         last_lat = 0;
    logic [1:0] last_err = 2'd0;

    // slave state
    int          aw_delay = 0;
    int          err_at = -1;
    int          aw_cnt = 0;
    int          wr_cnt = 0;
    bit          got_aw = 0;
    bit          got_w = 0;
    bit          b_pending = 0;
    bit          b_err = 0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_data = '0;

    // previous-cycle samples
    bit          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    bit          p_rv = 0, p_rr = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0;
    logic [1:0]  p_err = '0;

    axi_tlb_l1_programmer #(
        .NumEntries     (NE),
        .axi_lite_req_t (cfg_req_t),
        .axi_lite_resp_t(cfg_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i   (cmd_op_i),
        .cmd_idx_i  (cmd_idx_i),
        .cmd_first_i(cmd_first_i),
        .cmd_last_i (cmd_last_i),
        .cmd_base_i (cmd_base_i),
        .cmd_flags_i(cmd_flags_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_err_o  (rsp_err_o),
        .busy_o     (busy_o),
        .cfg_req_o  (cfg_req_o),
        .cfg_resp_i (cfg_resp_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic check_cycle();
        bit  aw_hs, w_hs, b_hs;
        bit  exp_rv;
        wr_t w, e;
        aw_hs = cfg_req_o.aw_valid && cfg_resp_i.aw_ready;
        w_hs  = cfg_req_o.w_valid && cfg_resp_i.w_ready;
        b_hs  = cfg_resp_i.b_valid && cfg_req_o.b_ready;

        chk(!cfg_req_o.ar_valid && !cfg_req_o.r_ready, "no_read",
            64'({cfg_req_o.ar_valid, cfg_req_o.r_ready}), 0);
        chk(cmd_ready_o == (!in_flight && !rst_i), "cmd_ready",
            64'(cmd_ready_o), 64'(!in_flight && !rst_i));
        chk(busy_o == in_flight, "busy", 64'(busy_o), 64'(in_flight));
        if (!in_flight)
            chk({cfg_req_o.aw_valid, cfg_req_o.w_valid, cfg_req_o.b_ready,
                 rsp_valid_o} == 4'b0, "idle_quiet",
                64'({cfg_req_o.aw_valid, cfg_req_o.w_valid,
                     cfg_req_o.b_ready, rsp_valid_o}), 0);
        if (zw && in_flight) begin
            exp_rv = (cyc - t_acc) >= exp_lat;
            chk(rsp_valid_o == exp_rv, "rsp_time", 64'(rsp_valid_o), 64'(exp_rv));
        end
        if (rsp_valid_o)
            chk(rsp_err_o == exp_err, "rsp_err", 64'(rsp_err_o), 64'(exp_err));
        if (p_rv && !p_rr)
            chk(rsp_valid_o && rsp_err_o == p_err, "rsp_hold",
                64'({rsp_valid_o, rsp_err_o}), 64'({1'b1, p_err}));
        if (p_awv && !p_awr)
            chk(cfg_req_o.aw_valid && cfg_req_o.aw.addr == p_awaddr, "aw_hold",
                64'(cfg_req_o.aw.addr), 64'(p_awaddr));
        if (p_awv && p_awr)
            chk(!cfg_req_o.aw_valid, "aw_drop", 64'(cfg_req_o.aw_valid), 0);
        if (p_wv && !p_wr)
            chk(cfg_req_o.w_valid && cfg_req_o.w.data == p_wdata, "w_hold",
                64'(cfg_req_o.w.data), 64'(p_wdata));
        if (p_wv && p_wr)
            chk(!cfg_req_o.w_valid, "w_drop", 64'(cfg_req_o.w_valid), 0);
        if (cfg_req_o.aw_valid)
            chk(cfg_req_o.aw.prot == 3'b000, "aw_prot", 64'(cfg_req_o.aw.prot), 0);
        if (cfg_req_o.w_valid)
            chk(cfg_req_o.w.strb == 4'hF, "w_strb", 64'(cfg_req_o.w.strb), 64'hF);
        if (cfg_req_o.b_ready)
            chk(b_pending, "b_ready_early", 64'(cfg_req_o.b_ready), 0);
        if (cfg_req_o.aw_valid || cfg_req_o.w_valid)
            chk(!b_pending, "one_outstanding", 64'(b_pending), 0);

        if (rsp_valid_o && !p_rv) begin
            rsp_cnt++;
            last_lat = cyc - t_acc;
            last_err = rsp_err_o;
            chk(exp_q.size() == 0, "writes_left", 64'(exp_q.size()), 0);
        end
        if (rsp_valid_o && rsp_ready_i) begin
            done_cnt++;
            in_flight = 0;
        end
        if (cmd_valid_i && cmd_ready_o) begin
            in_flight = 1;
            t_acc = cyc;
            wr_cnt = 0;
            acc_cnt++;
        end

        if (aw_hs) begin
            got_aw = 1;
            s_addr = cfg_req_o.aw.addr;
            aw_cnt = 0;
        end else if (cfg_req_o.aw_valid) begin
            aw_cnt++;
        end
        if (w_hs) begin
            got_w = 1;
            s_data = cfg_req_o.w.data;
        end
        if (b_hs) b_pending = 0;
        if (got_aw && got_w) begin
            got_aw = 0;
            got_w = 0;
            b_pending = 1;
            b_err = (wr_cnt == err_at);
            wr_cnt++;
            w.a = s_addr;
            w.d = s_data;
            log_q.push_back(w);
            if (exp_q.size() == 0) begin
                chk(0, "unexpected_write", 64'(s_addr), 0);
            end else begin
                e = exp_q.pop_front();
                chk(w.a == e.a, "wr_addr", 64'(w.a), 64'(e.a));
                chk(w.d == e.d, "wr_data", 64'(w.d), 64'(e.d));
            end
        end

        p_awv = cfg_req_o.aw_valid;
        p_awr = cfg_resp_i.aw_ready;
        p_awaddr = cfg_req_o.aw.addr;
        p_wv = cfg_req_o.w_valid;
        p_wr = cfg_resp_i.w_ready;
        p_wdata = cfg_req_o.w.data;
        p_rv = rsp_valid_o;
        p_rr = rsp_ready_i;
        p_err = rsp_err_o;

        if (rst_i) begin
            in_flight = 0;
            got_aw = 0;
            got_w = 0;
            b_pending = 0;
            aw_cnt = 0;
            exp_q.delete();
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
            p_rv = 0; p_rr = 0;
        end
    endtask

    // compare process and scripted config slave
    initial begin
        cfg_resp_i = '0;
        forever begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
            cfg_resp_i.aw_ready = cfg_req_o.aw_valid && (aw_cnt >= aw_delay);
            cfg_resp_i.w_ready  = cfg_req_o.w_valid;
            cfg_resp_i.b_valid  = b_pending;
            cfg_resp_i.b_resp   = b_err ? 2'b10 : 2'b00;
        end
    end

    task automatic setup_model(input bit op, input logic [1:0] idx,
                               input logic [19:0] first, input logic [19:0] last,
                               input logic [19:0] base, input logic [2:0] flags,
                               input int delay, input int err_step);
        bit          bad;
        logic [31:0] ea;
        wr_t         w;
        exp_q.delete();
        log_q.delete();
        bad = (int'(idx) >= NE) || (!op && first > last);
        ea = 32'(idx) * 32'd16;
        if (!bad) begin
            w.a = ea + 32'hC; w.d = 32'd0; exp_q.push_back(w);
            if (!op) begin
                w.a = ea;         w.d = 32'(first); exp_q.push_back(w);
                w.a = ea + 32'h4; w.d = 32'(last);  exp_q.push_back(w);
                w.a = ea + 32'h8; w.d = 32'(base);  exp_q.push_back(w);
                w.a = ea + 32'hC; w.d = 32'(flags); exp_q.push_back(w);
            end
            if (err_step >= 0)
                while (exp_q.size() > err_step + 1) void'(exp_q.pop_back());
        end
        exp_err = bad ? 2'd1 : (err_step >= 0 ? 2'd2 : 2'd0);
        exp_lat = 1 + 2 * exp_q.size();
        zw = (delay == 0);
        aw_delay = delay;
        err_at = err_step;
    endtask

    task automatic issue(input bit op, input logic [1:0] idx,
                         input logic [19:0] first, input logic [19:0] last,
                         input logic [19:0] base, input logic [2:0] flags);
        int  n;
        bit  ok;
        n = acc_cnt;
        ok = 0;
        @(posedge clk);
        #1;
        cmd_op_i = op; cmd_idx_i = idx; cmd_first_i = first;
        cmd_last_i = last; cmd_base_i = base; cmd_flags_i = flags;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (acc_cnt != n) begin ok = 1; break; end
        end
        chk(ok, "accept_timeout", 64'(ok), 1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        cmd_op_i = 1'($urandom);
        cmd_idx_i = 2'($urandom);
        cmd_first_i = 20'($urandom);
        cmd_last_i = 20'($urandom);
        cmd_base_i = 20'($urandom);
        cmd_flags_i = 3'($urandom);
    endtask

    task automatic finish_rsp(input int hold);
        int n;
        bit ok;
        n = rsp_cnt;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_cnt != n) begin ok = 1; break; end
            @(negedge clk);
            #1;
        end
        chk(ok, "rsp_timeout", 64'(ok), 1);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        n = done_cnt;
        ok = 0;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != n) begin ok = 1; break; end
        end
        chk(ok, "rsp_hs_timeout", 64'(ok), 1);
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic run_cmd(input bit op, input logic [1:0] idx,
                           input logic [19:0] first, input logic [19:0] last,
                           input logic [19:0] base, input logic [2:0] flags,
                           input int delay, input int err_step, input int hold);
        setup_model(op, idx, first, last, base, flags, delay, err_step);
        issue(op, idx, first, last, base, flags);
        finish_rsp(hold);
    endtask

    initial begin
        logic [31:0] lit_a[5];
        logic [31:0] lit_d[5];
        bit          found;
        lit_a = '{32'h2C, 32'h20, 32'h24, 32'h28, 32'h2C};
        lit_d = '{32'h0, 32'h10, 32'h1F, 32'h80000, 32'h7};

        // reset state
        repeat (3) @(negedge clk);
        chk(cmd_ready_o == 1'b0, "rst_cmd_ready", 64'(cmd_ready_o), 0);
        chk(busy_o == 1'b0, "rst_busy", 64'(busy_o), 0);
        chk(rsp_valid_o == 1'b0, "rst_rsp_valid", 64'(rsp_valid_o), 0);
        chk(rsp_err_o == 2'd0, "rst_rsp_err", 64'(rsp_err_o), 0);
        chk(!cfg_req_o.aw_valid && !cfg_req_o.w_valid && !cfg_req_o.b_ready,
            "rst_bus", 64'({cfg_req_o.aw_valid, cfg_req_o.w_valid,
                            cfg_req_o.b_ready}), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk(cmd_ready_o == 1'b1, "ready_after_rst", 64'(cmd_ready_o), 1);

        // program, zero-wait slave
        run_cmd(1'b0, 2'd2, 20'h10, 20'h1F, 20'h80000, 3'b111, 0, -1, 0);
        chk(last_lat == 11, "prog_lat", 64'(last_lat), 11);
        chk(last_err == 2'd0, "prog_err", 64'(last_err), 0);
        chk(log_q.size() == 5, "prog_nwr", 64'(log_q.size()), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk(log_q[i].a == lit_a[i], "prog_lit_addr", 64'(log_q[i].a), 64'(lit_a[i]));
            chk(log_q[i].d == lit_d[i], "prog_lit_data", 64'(log_q[i].d), 64'(lit_d[i]));
        end

        // same command, AWREADY delayed 3 cycles on every step
        run_cmd(1'b0, 2'd2, 20'h10, 20'h1F, 20'h80000, 3'b111, 3, -1, 0);
        chk(last_err == 2'd0, "slow_err", 64'(last_err), 0);
        chk(log_q.size() == 5, "slow_nwr", 64'(log_q.size()), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            chk(log_q[i].d == lit_d[i], "slow_lit_data", 64'(log_q[i].d), 64'(lit_d[i]));

        // SLVERR on step 2, response held 4 cycles
        run_cmd(1'b0, 2'd1, 20'h3, 20'h9, 20'h44, 3'b011, 0, 2, 4);
        chk(last_lat == 7, "slverr_lat", 64'(last_lat), 7);
        chk(last_err == 2'd2, "slverr_err", 64'(last_err), 2);
        chk(log_q.size() == 3, "slverr_nwr", 64'(log_q.size()), 3);

        // bad index
        run_cmd(1'b0, 2'd3, 20'h1, 20'h2, 20'h3, 3'b001, 0, -1, 0);
        chk(last_lat == 1, "badidx_lat", 64'(last_lat), 1);
        chk(last_err == 2'd1, "badidx_err", 64'(last_err), 1);
        chk(log_q.size() == 0, "badidx_nwr", 64'(log_q.size()), 0);

        // first > last
        run_cmd(1'b0, 2'd0, 20'h20, 20'h1F, 20'h3, 3'b001, 0, -1, 2);
        chk(last_lat == 1, "badrng_lat", 64'(last_lat), 1);
        chk(last_err == 2'd1, "badrng_err", 64'(last_err), 1);
        chk(log_q.size() == 0, "badrng_nwr", 64'(log_q.size()), 0);

        // invalidate entry 0
        run_cmd(1'b1, 2'd0, 20'h20, 20'h1F, 20'h0, 3'b000, 0, -1, 0);
        chk(last_lat == 3, "inv_lat", 64'(last_lat), 3);
        chk(last_err == 2'd0, "inv_err", 64'(last_err), 0);
        chk(log_q.size() == 1, "inv_nwr", 64'(log_q.size()), 1);
        if (log_q.size() > 0) begin
            chk(log_q[0].a == 32'h0C, "inv_addr", 64'(log_q[0].a), 64'h0C);
            chk(log_q[0].d == 32'h0, "inv_data", 64'(log_q[0].d), 0);
        end

        // first == last is a legal range
        run_cmd(1'b0, 2'd0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 3'b001, 0, -1, 0);
        chk(last_lat == 11, "eq_lat", 64'(last_lat), 11);
        chk(last_err == 2'd0, "eq_err", 64'(last_err), 0);

        // reset during step 3 with aw_valid high
        setup_model(1'b0, 2'd2, 20'h10, 20'h1F, 20'h80000, 3'b111, 3, -1);
        issue(1'b0, 2'd2, 20'h10, 20'h1F, 20'h80000, 3'b111);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt == 3 && cfg_req_o.aw_valid) begin found = 1; break; end
        end
        chk(found, "step3_timeout", 64'(found), 1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk(!cfg_req_o.aw_valid && !cfg_req_o.w_valid, "rst_mid_valids",
            64'({cfg_req_o.aw_valid, cfg_req_o.w_valid}), 0);
        chk(busy_o == 1'b0, "rst_mid_busy", 64'(busy_o), 0);
        chk(cmd_ready_o == 1'b1, "rst_mid_ready", 64'(cmd_ready_o), 1);

        run_cmd(1'b0, 2'd1, 20'h5, 20'h5, 20'h123, 3'b011, 0, -1, 0);
        chk(last_lat == 11, "after_rst_lat", 64'(last_lat), 11);
        if (log_q.size() > 0) begin
            chk(log_q[0].a == 32'h1C, "after_rst_addr0", 64'(log_q[0].a), 64'h1C);
            chk(log_q[0].d == 32'h0, "after_rst_data0", 64'(log_q[0].d), 0);
        end else begin
            chk(0, "after_rst_nwr", 0, 5);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
